// File: rtl/z80_io_initiator_if.sv
// Wishbone register port plus Z80 I/O bus pins of the Z80 I/O initiator.
// The slave view belongs to the initiator block; the master view belongs to the SoC/bench side.
interface z80_io_initiator_if;
    logic        wb_cyc_in;
    logic        wb_stb_in;
    logic        wb_we_in;
    logic [31:0] wb_addr_in;
    logic [31:0] wb_data_in;
    logic        wb_ack_out;
    logic [31:0] wb_data_out;
    logic [7:0]  z80_address_bus;
    logic [7:0]  z80_data_bus_out;
    logic [7:0]  z80_data_bus_in;
    logic        z80_data_oe;
    logic        z80_write_strobe_b;
    logic        z80_read_strobe_b;
    logic        irq_done_out;

    modport slave (
        input  wb_cyc_in, wb_stb_in, wb_we_in, wb_addr_in, wb_data_in, z80_data_bus_in,
        output wb_ack_out, wb_data_out, z80_address_bus, z80_data_bus_out, z80_data_oe,
        output z80_write_strobe_b, z80_read_strobe_b, irq_done_out
    );

    modport master (
        output wb_cyc_in, wb_stb_in, wb_we_in, wb_addr_in, wb_data_in, z80_data_bus_in,
        input  wb_ack_out, wb_data_out, z80_address_bus, z80_data_bus_out, z80_data_oe,
        input  z80_write_strobe_b, z80_read_strobe_b, irq_done_out
    );
endinterface

// File: rtl/z80_io_initiator.sv
// Z80 I/O initiator: Wishbone ack one clock after request; a bus cycle spans SETUP+STROBE+HOLD clocks.
// No backpressure: every access is acked; a command arriving while busy is dropped and flagged as overrun.
module z80_io_initiator #(
    parameter logic [31:0] BASE_ADDRESS   = 32'h3000_0100,
    parameter logic [31:0] CMD_ADDRESS    = BASE_ADDRESS,
    parameter logic [31:0] DATA_ADDRESS   = BASE_ADDRESS + 32'd4,
    parameter logic [31:0] STATUS_ADDRESS = BASE_ADDRESS + 32'd8,
    parameter int unsigned SETUP_CYCLES   = 2,
    parameter int unsigned STROBE_CYCLES  = 4,
    parameter int unsigned HOLD_CYCLES    = 2
) (
    input  logic              clk,
    input  logic              reset_b,
    z80_io_initiator_if.slave bus
);
    localparam logic [7:0] SETUP_N  = (SETUP_CYCLES  < 1) ? 8'd1 : 8'(SETUP_CYCLES);
    localparam logic [7:0] STROBE_N = (STROBE_CYCLES < 1) ? 8'd1 : 8'(STROBE_CYCLES);
    localparam logic [7:0] HOLD_N   = (HOLD_CYCLES   < 1) ? 8'd1 : 8'(HOLD_CYCLES);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic        strobe_on, strobe_off, cycle_end;
    logic [8:0]  cmd_q;
    logic [7:0]  tx, rx;
    logic        done, overrun, busy;
    logic        wb_req, wb_wr, wb_rd;
    logic        hit_cmd, hit_data, hit_status;
    logic        cmd_wr, start, status_rd;
    logic [31:0] rd_mux;
    logic        unused_ok;

    assign unused_ok  = ^bus.wb_data_in[31:9];
    assign wb_req     = bus.wb_cyc_in & bus.wb_stb_in & ~bus.wb_ack_out;
    assign wb_wr      = wb_req & bus.wb_we_in;
    assign wb_rd      = wb_req & ~bus.wb_we_in;
    assign hit_cmd    = (bus.wb_addr_in == CMD_ADDRESS);
    assign hit_data   = (bus.wb_addr_in == DATA_ADDRESS);
    assign hit_status = (bus.wb_addr_in == STATUS_ADDRESS);
    assign busy       = (state != IDLE);
    assign cmd_wr     = wb_wr & hit_cmd;
    assign start      = cmd_wr & ~busy;
    assign status_rd  = wb_rd & hit_status;
    assign bus.irq_done_out = done;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Each phase loads its length minus one and advances when the counter reaches zero.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        strobe_on  = 1'b0;
        strobe_off = 1'b0;
        cycle_end  = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_nxt = SETUP;
                cnt_nxt   = SETUP_N - 8'd1;
            end
            SETUP: if (cnt == 8'd0) begin
                state_nxt = STROBE;
                cnt_nxt   = STROBE_N - 8'd1;
                strobe_on = 1'b1;
            end else cnt_nxt = cnt - 8'd1;
            STROBE: if (cnt == 8'd0) begin
                state_nxt  = HOLD;
                cnt_nxt    = HOLD_N - 8'd1;
                strobe_off = 1'b1;
            end else cnt_nxt = cnt - 8'd1;
            HOLD: if (cnt == 8'd0) begin
                state_nxt = IDLE;
                cnt_nxt   = 8'd0;
                cycle_end = 1'b1;
            end else cnt_nxt = cnt - 8'd1;
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            cmd_q                  <= 9'd0;
            tx                     <= 8'd0;
            rx                     <= 8'd0;
            bus.z80_address_bus    <= 8'd0;
            bus.z80_data_bus_out   <= 8'd0;
            bus.z80_data_oe        <= 1'b0;
            bus.z80_write_strobe_b <= 1'b1;
            bus.z80_read_strobe_b  <= 1'b1;
        end else begin
            if (wb_wr && hit_data) tx <= bus.wb_data_in[7:0];
            if (start) begin
                cmd_q                <= bus.wb_data_in[8:0];
                bus.z80_address_bus  <= bus.wb_data_in[7:0];
                bus.z80_data_bus_out <= tx;
                bus.z80_data_oe      <= bus.wb_data_in[8];
            end
            if (strobe_on) begin
                if (cmd_q[8]) bus.z80_write_strobe_b <= 1'b0;
                else          bus.z80_read_strobe_b  <= 1'b0;
            end
            // Target holds data stable while the strobe is low, so no synchronizer here.
            if (strobe_off) begin
                bus.z80_write_strobe_b <= 1'b1;
                bus.z80_read_strobe_b  <= 1'b1;
                if (!cmd_q[8]) rx <= bus.z80_data_bus_in;
            end
            if (cycle_end) bus.z80_data_oe <= 1'b0;
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        if (hit_cmd)         rd_mux = {23'd0, cmd_q};
        else if (hit_data)   rd_mux = {24'd0, rx};
        else if (hit_status) rd_mux = {29'd0, overrun, done, busy};
    end

    // Sticky flags: a set on the same edge as a STATUS-read clear wins.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            done            <= 1'b0;
            overrun         <= 1'b0;
            bus.wb_ack_out  <= 1'b0;
            bus.wb_data_out <= 32'd0;
        end else begin
            if (cycle_end)      done <= 1'b1;
            else if (status_rd) done <= 1'b0;
            if (cmd_wr && busy) overrun <= 1'b1;
            else if (status_rd) overrun <= 1'b0;
            bus.wb_ack_out  <= wb_req;
            bus.wb_data_out <= wb_rd ? rd_mux : 32'd0;
        end
    end
endmodule

// File: tb/tb_z80_io_initiator.sv
module tb_z80_io_initiator;
    localparam logic [31:0] BASE  = 32'h3000_0100;
    localparam logic [31:0] CMD   = BASE;
    localparam logic [31:0] DATA  = BASE + 32'd4;
    localparam logic [31:0] STAT  = BASE + 32'd8;
    localparam logic [31:0] UNMAP = BASE + 32'd12;
    localparam int SA = 2, TA = 4, HA = 2;

    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] adr = 32'd0, wdat = 32'd0;
    logic [7:0]  zin = 8'd0;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    z80_io_initiator_if ia();
    z80_io_initiator_if ib();
    assign ia.wb_cyc_in = cyc;   assign ib.wb_cyc_in = cyc;
    assign ia.wb_stb_in = stb;   assign ib.wb_stb_in = stb;
    assign ia.wb_we_in = we;     assign ib.wb_we_in = we;
    assign ia.wb_addr_in = adr;  assign ib.wb_addr_in = adr;
    assign ia.wb_data_in = wdat; assign ib.wb_data_in = wdat;
    assign ia.z80_data_bus_in = zin;
    assign ib.z80_data_bus_in = zin;

    z80_io_initiator dut_a (.clk(clk), .reset_b(reset_b), .bus(ia.slave));
    z80_io_initiator #(.SETUP_CYCLES(1), .STROBE_CYCLES(1), .HOLD_CYCLES(1))
        dut_b (.clk(clk), .reset_b(reset_b), .bus(ib.slave));

    // Bus monitor: clocks spent low/high and pulse counts, sampled on the falling edge.
    int wr_low_a = 0, rd_low_a = 0, oe_a = 0, wr_pul_a = 0, rd_pul_a = 0, both_a = 0;
    int wr_low_b = 0, rd_low_b = 0, oe_b = 0, wr_pul_b = 0;
    logic wr_prev_a = 1'b1, rd_prev_a = 1'b1, wr_prev_b = 1'b1;
    always @(negedge clk) begin
        if (!ia.z80_write_strobe_b) wr_low_a++;
        if (!ia.z80_read_strobe_b) rd_low_a++;
        if (ia.z80_data_oe) oe_a++;
        if (!ia.z80_write_strobe_b && wr_prev_a) wr_pul_a++;
        if (!ia.z80_read_strobe_b && rd_prev_a) rd_pul_a++;
        if (!ia.z80_write_strobe_b && !ia.z80_read_strobe_b) both_a++;
        wr_prev_a = ia.z80_write_strobe_b;
        rd_prev_a = ia.z80_read_strobe_b;
        if (!ib.z80_write_strobe_b) wr_low_b++;
        if (!ib.z80_read_strobe_b) rd_low_b++;
        if (ib.z80_data_oe) oe_b++;
        if (!ib.z80_write_strobe_b && wr_prev_b) wr_pul_b++;
        wr_prev_b = ib.z80_write_strobe_b;
    end

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] rd, output logic ack1, output logic ack2,
                             output logic [31:0] rd_idle);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
        @(posedge clk); #1;
        ack1 = ia.wb_ack_out; rd = ia.wb_data_out;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        ack2 = ia.wb_ack_out; rd_idle = ia.wb_data_out;
    endtask

    task automatic wb_wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r, ri;
        logic k1, k2;
        wb_access(1'b1, a, d, r, k1, k2, ri);
    endtask

    task automatic wb_rd(input logic [31:0] a, output logic [31:0] r);
        logic [31:0] ri;
        logic k1, k2;
        wb_access(1'b0, a, 32'd0, r, k1, k2, ri);
    endtask

    task automatic test_reset;
        logic [31:0] r;
        reset_b = 1'b0;
        run(3);
        checks++; if (ia.z80_write_strobe_b !== 1'b1) begin errors++; $display("FAIL reset_wr_strobe got %b exp 1", ia.z80_write_strobe_b); end
        checks++; if (ia.z80_read_strobe_b !== 1'b1) begin errors++; $display("FAIL reset_rd_strobe got %b exp 1", ia.z80_read_strobe_b); end
        checks++; if (ia.z80_data_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b exp 0", ia.z80_data_oe); end
        checks++; if ({ia.z80_address_bus, ia.z80_data_bus_out} !== 16'h0) begin errors++; $display("FAIL reset_addr_data got %h exp 0000", {ia.z80_address_bus, ia.z80_data_bus_out}); end
        checks++; if ({ia.wb_ack_out, ia.irq_done_out, ia.wb_data_out} !== 34'h0) begin errors++; $display("FAIL reset_wb_irq got %h exp 0", {ia.wb_ack_out, ia.irq_done_out, ia.wb_data_out}); end
        @(negedge clk); reset_b = 1'b1;
        run(1);
        wb_rd(STAT, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_status got %h exp 0", r); end
        wb_rd(DATA, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_rx got %h exp 0", r); end
    endtask

    task automatic test_write_cycle;
        logic [31:0] r;
        int w0, r0, o0, p0;
        w0 = wr_low_a; r0 = rd_low_a; o0 = oe_a; p0 = wr_pul_a;
        wb_wr(DATA, 32'hA5);
        wb_wr(CMD, 32'h142);
        checks++; if ({ia.z80_address_bus, ia.z80_data_bus_out, ia.z80_data_oe} !== {8'h42, 8'hA5, 1'b1}) begin errors++; $display("FAIL wr_setup_pins got %h/%h/%b exp 42/a5/1", ia.z80_address_bus, ia.z80_data_bus_out, ia.z80_data_oe); end
        checks++; if (ia.z80_write_strobe_b !== 1'b1) begin errors++; $display("FAIL wr_setup_strobe got %b exp 1", ia.z80_write_strobe_b); end
        run(12);
        checks++; if (wr_low_a - w0 != TA || wr_pul_a - p0 != 1) begin errors++; $display("FAIL wr_strobe_width got %0d clocks %0d pulses exp %0d/1", wr_low_a - w0, wr_pul_a - p0, TA); end
        checks++; if (rd_low_a - r0 != 0) begin errors++; $display("FAIL wr_rd_strobe got %0d exp 0", rd_low_a - r0); end
        checks++; if (oe_a - o0 != SA + TA + HA) begin errors++; $display("FAIL wr_busy_len got %0d exp %0d", oe_a - o0, SA + TA + HA); end
        checks++; if (ia.irq_done_out !== 1'b1) begin errors++; $display("FAIL wr_irq got %b exp 1", ia.irq_done_out); end
        wb_rd(STAT, r);
        checks++; if (r !== 32'h2) begin errors++; $display("FAIL wr_status1 got %h exp 2", r); end
        wb_rd(STAT, r);
        checks++; if (r !== 32'h0 || ia.irq_done_out !== 1'b0) begin errors++; $display("FAIL wr_status2 got %h irq %b exp 0/0", r, ia.irq_done_out); end
    endtask

    task automatic test_read_cycle;
        logic [31:0] r;
        int r0, o0, w0;
        r0 = rd_low_a; o0 = oe_a; w0 = wr_low_a;
        zin = 8'h3C;
        wb_wr(CMD, 32'h010);
        run(12);
        zin = 8'hC3;
        checks++; if (rd_low_a - r0 != TA || wr_low_a - w0 != 0) begin errors++; $display("FAIL rd_strobe got rd %0d wr %0d exp %0d/0", rd_low_a - r0, wr_low_a - w0, TA); end
        checks++; if (oe_a - o0 != 0) begin errors++; $display("FAIL rd_oe got %0d exp 0", oe_a - o0); end
        wb_rd(DATA, r);
        checks++; if (r !== 32'h3C) begin errors++; $display("FAIL rd_data got %h exp 3c", r); end
        wb_rd(STAT, r);
        checks++; if (r !== 32'h2) begin errors++; $display("FAIL rd_done got %h exp 2", r); end
    endtask

    task automatic test_overrun;
        logic [31:0] r;
        int p0;
        p0 = wr_pul_a;
        wb_wr(CMD, 32'h110);
        wb_wr(CMD, 32'h120);
        wb_rd(STAT, r);
        checks++; if (r !== 32'h5) begin errors++; $display("FAIL ovr_status_busy got %h exp 5", r); end
        wb_wr(CMD, 32'h130);
        checks++; if (ia.z80_address_bus !== 8'h10) begin errors++; $display("FAIL ovr_addr_busy got %h exp 10", ia.z80_address_bus); end
        run(12);
        wb_rd(STAT, r);
        checks++; if (r !== 32'h6) begin errors++; $display("FAIL ovr_status_done got %h exp 6", r); end
        checks++; if (wr_pul_a - p0 != 1 || ia.z80_address_bus !== 8'h10) begin errors++; $display("FAIL ovr_pulses got %0d addr %h exp 1/10", wr_pul_a - p0, ia.z80_address_bus); end
        wb_rd(CMD, r);
        checks++; if (r !== 32'h110) begin errors++; $display("FAIL ovr_cmd_reg got %h exp 110", r); end
    endtask

    task automatic test_async_reset;
        logic [31:0] r;
        int w0, r0, o0;
        wb_wr(CMD, 32'h1AA);
        @(posedge clk); #2;
        checks++; if (ia.z80_write_strobe_b !== 1'b0) begin errors++; $display("FAIL rst_pre_strobe got %b exp 0", ia.z80_write_strobe_b); end
        #1 reset_b = 1'b0;
        #1;
        checks++; if ({ia.z80_write_strobe_b, ia.z80_read_strobe_b, ia.z80_data_oe} !== 3'b110) begin errors++; $display("FAIL rst_async_pins got %b exp 110", {ia.z80_write_strobe_b, ia.z80_read_strobe_b, ia.z80_data_oe}); end
        @(negedge clk); reset_b = 1'b1;
        run(1);
        w0 = wr_low_a; r0 = rd_low_a; o0 = oe_a;
        run(15);
        checks++; if (wr_low_a - w0 + rd_low_a - r0 + oe_a - o0 != 0) begin errors++; $display("FAIL rst_bus_quiet got %0d exp 0", wr_low_a - w0 + rd_low_a - r0 + oe_a - o0); end
        wb_rd(STAT, r);
        checks++; if (r !== 32'h0 || ia.irq_done_out !== 1'b0) begin errors++; $display("FAIL rst_status got %h irq %b exp 0/0", r, ia.irq_done_out); end
    endtask

    task automatic test_wishbone;
        logic [31:0] r, ri;
        logic k1, k2;
        wb_access(1'b0, UNMAP, 32'd0, r, k1, k2, ri);
        checks++; if ({k1, k2} !== 2'b10) begin errors++; $display("FAIL wb_ack_pulse got %b exp 10", {k1, k2}); end
        checks++; if (r !== 32'h0 || ri !== 32'h0) begin errors++; $display("FAIL wb_unmapped_rd got %h idle %h exp 0/0", r, ri); end
        wb_access(1'b1, UNMAP, 32'hFFFF_FFFF, r, k1, k2, ri);
        checks++; if ({k1, k2} !== 2'b10) begin errors++; $display("FAIL wb_unmapped_wr_ack got %b exp 10", {k1, k2}); end
        wb_wr(DATA, 32'h11);
        wb_wr(CMD, 32'h155);
        wb_wr(DATA, 32'h77);
        checks++; if (ia.z80_data_bus_out !== 8'h11) begin errors++; $display("FAIL wb_tx_snapshot got %h exp 11", ia.z80_data_bus_out); end
        run(12);
        wb_rd(STAT, r);
        wb_wr(CMD, 32'h156);
        checks++; if ({ia.z80_address_bus, ia.z80_data_bus_out} !== 16'h5677) begin errors++; $display("FAIL wb_next_tx got %h exp 5677", {ia.z80_address_bus, ia.z80_data_bus_out}); end
        run(12);
    endtask

    task automatic test_back_to_back;
        logic [3:0] acks;
        logic [31:0] dat [4];
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = CMD;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            acks[i] = ia.wb_ack_out;
            dat[i] = ia.wb_data_out;
        end
        cyc = 1'b0; stb = 1'b0;
        run(1);
        checks++; if (acks !== 4'b0101) begin errors++; $display("FAIL b2b_ack got %b exp 0101", acks); end
        checks++; if (dat[0] !== 32'h156 || dat[1] !== 32'h0 || dat[2] !== 32'h156) begin errors++; $display("FAIL b2b_data got %h %h %h exp 156 0 156", dat[0], dat[1], dat[2]); end
    endtask

    task automatic test_min_timing;
        logic [31:0] r;
        int w0, p0, o0, r0;
        wb_rd(STAT, r);
        w0 = wr_low_b; p0 = wr_pul_b; o0 = oe_b; r0 = rd_low_b;
        wb_wr(CMD, 32'h15A);
        checks++; if (ib.z80_write_strobe_b !== 1'b0) begin errors++; $display("FAIL min_strobe_early got %b exp 0", ib.z80_write_strobe_b); end
        run(12);
        checks++; if (wr_low_b - w0 != 1 || wr_pul_b - p0 != 1 || rd_low_b - r0 != 0) begin errors++; $display("FAIL min_strobe got %0d clocks %0d pulses rd %0d exp 1/1/0", wr_low_b - w0, wr_pul_b - p0, rd_low_b - r0); end
        checks++; if (oe_b - o0 != 3 || ib.irq_done_out !== 1'b1) begin errors++; $display("FAIL min_busy got %0d irq %b exp 3/1", oe_b - o0, ib.irq_done_out); end
        wb_rd(STAT, r);
        checks++; if (r !== 32'h2) begin errors++; $display("FAIL min_status_a got %h exp 2", r); end
    endtask

    task automatic test_random;
        logic [31:0] r;
        logic [7:0] a8, txb, zb;
        logic w, ovr;
        logic [7:0] rx_m;
        int w0, r0, o0;
        rx_m = 8'h00;
        for (int i = 0; i < 24; i++) begin
            a8 = 8'($urandom_range(0, 255));
            txb = 8'($urandom_range(0, 255));
            zb = 8'($urandom_range(0, 255));
            w = 1'($urandom_range(0, 1));
            ovr = ($urandom_range(0, 3) == 0);
            wb_wr(DATA, {24'd0, txb});
            zin = zb;
            w0 = wr_low_a; r0 = rd_low_a; o0 = oe_a;
            wb_wr(CMD, {23'd0, w, a8});
            checks++; if ({ia.z80_address_bus, ia.z80_data_bus_out, ia.z80_data_oe} !== {a8, txb, w}) begin errors++; $display("FAIL rnd_pins[%0d] got %h/%h/%b exp %h/%h/%b", i, ia.z80_address_bus, ia.z80_data_bus_out, ia.z80_data_oe, a8, txb, w); end
            if (ovr) wb_wr(CMD, {23'd0, ~w, ~a8});
            run(10);
            zin = ~zb;
            if (!w) rx_m = zb;
            checks++; if (wr_low_a - w0 != (w ? TA : 0) || rd_low_a - r0 != (w ? 0 : TA)) begin errors++; $display("FAIL rnd_strobe[%0d] got wr %0d rd %0d exp we=%b width %0d", i, wr_low_a - w0, rd_low_a - r0, w, TA); end
            checks++; if (oe_a - o0 != (w ? SA + TA + HA : 0)) begin errors++; $display("FAIL rnd_oe[%0d] got %0d exp %0d", i, oe_a - o0, w ? SA + TA + HA : 0); end
            wb_rd(DATA, r);
            checks++; if (r !== {24'd0, rx_m}) begin errors++; $display("FAIL rnd_rx[%0d] got %h exp %h", i, r, rx_m); end
            wb_rd(STAT, r);
            checks++; if (r !== {29'd0, ovr, 2'b10}) begin errors++; $display("FAIL rnd_status[%0d] got %h exp %h", i, r, {29'd0, ovr, 2'b10}); end
            wb_rd(CMD, r);
            checks++; if (r !== {23'd0, w, a8}) begin errors++; $display("FAIL rnd_cmd[%0d] got %h exp %h", i, r, {23'd0, w, a8}); end
        end
        checks++; if (both_a != 0) begin errors++; $display("FAIL both_strobes_low got %0d exp 0", both_a); end
    endtask

    initial begin
        test_reset();
        test_write_cycle();
        test_read_cycle();
        test_overrun();
        test_async_reset();
        test_wishbone();
        test_back_to_back();
        test_min_timing();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/z80_io_initiator.md
Name: z80_io_initiator

Overview:
- Wishbone-controlled Z80 I/O bus initiator: the SoC posts a command, and the block runs one Z80-style I/O read or write cycle on GPIO pins.
- It is the bus master counterpart of the zube mailbox's Z80 target side, used to drive zube or other Z80 I/O targets from Caravel.
- Timing (setup/strobe/hold) is parameterised.
- The block sits beside zube inside the user project wrapper; pad OEB mapping is done outside the block using z80_data_oe.

Parameters:
BASE_ADDRESS, 32'h3000_0100, Wishbone base.
CMD_ADDRESS, BASE_ADDRESS, command register.
DATA_ADDRESS, BASE_ADDRESS + 4, write-data / read-result register.
STATUS_ADDRESS, BASE_ADDRESS + 8, status register.
SETUP_CYCLES, 2, clocks address/data valid before strobe (1..255).
STROBE_CYCLES, 4, clocks strobe held low (1..255).
HOLD_CYCLES, 2, clocks address/data held after strobe (1..255).

Ports:
clk  input  1  system (Wishbone) clock; one clock domain
reset_b  input  1  asynchronous active-low reset
wb_cyc_in  input  1  Wishbone cycle
wb_stb_in  input  1  Wishbone strobe
wb_we_in  input  1  1 = write
wb_addr_in  input  32  byte address
wb_data_in  input  32  write data
wb_ack_out  output  1  transfer acknowledge
wb_data_out  output  32  read data
z80_address_bus  output  8  I/O port address
z80_data_bus_out  output  8  data driven during write cycles
z80_data_bus_in  input  8  data sampled during read cycles
z80_data_oe  output  1  1 = block drives data bus (write cycle)
z80_write_strobe_b  output  1  active-low write strobe
z80_read_strobe_b  output  1  active-low read strobe
irq_done_out  output  1  cycle-complete IRQ; level, equals STATUS.done

Behaviour:
Reset (async, reset_b low):
- State IDLE; all counters 0.
- Strobes high; z80_data_oe 0; address and data_out 0.
- wb_ack_out 0; wb_data_out 0.
- TX, RX and STATUS registers 0; irq_done_out 0.

Wishbone:
- A request is cyc & stb & !ack. It is acked on the next clock with a single-cycle ack pulse, so back-to-back requests see ack alternate.
- Register writes take effect at the edge that raises ack.
- Read data is registered with ack; wb_data_out returns 0 when ack is low.
- Unmapped addresses are acked; reads return 0 and writes are ignored.

Registers:
- CMD (write): [7:0] port address, [8] 1 = write / 0 = read. Reads return the last accepted command in [8:0].
- DATA: write sets TX[7:0]. Read returns RX[7:0], the byte captured by the last read cycle.
- STATUS (read-only): [0] busy, [1] done (sticky), [2] overrun (sticky). A STATUS read clears done and overrun at its ack edge.

FSM (IDLE -> SETUP -> STROBE -> HOLD -> IDLE):
- IDLE, CMD write accepted:
  - address <= cmd[7:0]; data_out <= TX (TX is snapshotted, so later DATA writes do not affect the cycle).
  - z80_data_oe <= cmd[8].
  - Enter SETUP; busy = 1.
- SETUP lasts SETUP_CYCLES clocks, then enters STROBE.
  - Entering STROBE drives write_strobe_b low if cmd[8] = 1, else read_strobe_b low.
- STROBE lasts STROBE_CYCLES clocks.
  - At the edge ending the last strobe clock: the strobe goes high; for a read, RX <= z80_data_bus_in, with no synchronizer because the target holds data stable while the strobe is low.
  - Then enter HOLD.
- HOLD lasts HOLD_CYCLES clocks. Address, data_out and oe are unchanged.
  - At the end: oe <= 0, address and data_out are held, state IDLE, busy 0, done 1.
- Total busy time = SETUP_CYCLES + STROBE_CYCLES + HOLD_CYCLES clocks. The strobe is exactly STROBE_CYCLES clocks wide.

Boundary cases:
- Exactly one strobe is asserted at a time; the other strobe is never low.
- A CMD write while busy is acked and ignored, and sets overrun. This includes a write landing on the same edge HOLD ends.
- Done being set on the same edge as a STATUS-read clear: set wins.
- reset_b low mid-cycle: strobes deassert and oe drops immediately (asynchronous). No done is generated.
- SETUP_CYCLES, STROBE_CYCLES and HOLD_CYCLES are clamped to a minimum of 1; counters are 8 bits.

Test Plan:
1. Write DATA = 0xA5, then CMD = 0x142 -> address 0x42, oe = 1, data_out 0xA5. Two clocks later write_strobe_b is low for exactly 4 clocks; read_strobe_b stays high. Busy lasts 8 clocks, then irq_done_out = 1. First STATUS read = 0x2, second = 0x0, irq low.
2. CMD = 0x010 with the target driving 0x3C -> read_strobe_b low for 4 clocks, oe 0 throughout. DATA read returns 0x3C; done set.
3. CMD = 0x110, then CMD = 0x120 issued while busy -> only one strobe pulse, address stays 0x10. STATUS = 0x5 during busy, 0x6 after completion.
4. Assert reset_b during STROBE -> strobe high and oe 0 without waiting for a clock edge. After release STATUS = 0, irq 0, and no further bus activity.
5. Wishbone: every access gets exactly one single-clock ack. A read of BASE+0xC returns 0. Writing DATA = 0x77 mid-cycle does not change data_out; the next command drives 0x77.
6. Set SETUP/STROBE/HOLD = 1/1/1 and issue a write -> strobe low for exactly 1 clock; busy lasts 3 clocks.
